// File: rtl/mem_xfer_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mem_xfer_ctrl
// Purpose  : Sequencer for the Mini-SRC memory-side datapath. Drives the MAR
//            and MDR load enables, the MDR input-mux select and the memory
//            read/write strobes for one load or store at a time. It waits on
//            the memory ready handshake with a bounded timeout.
//            Holds sequencing state only, plus a wait counter; no data path.
// Ports    : clock        - system clock, rising edge
//            clear        - synchronous active-low reset
//            start_read   - one-cycle load request (MAR <- bus, MDR <- memory)
//            start_write  - one-cycle store request (MAR, MDR <- bus, write)
//            mem_ready    - memory acknowledges the current access
//            MARin        - MAR load enable
//            MDRin        - MDR load enable
//            MDR_read     - MDR mux select (1 = Mdatain, 0 = BusMuxOut)
//            mem_read     - memory read strobe
//            mem_write    - memory write strobe
//            busy         - high whenever not idle
//            done         - one-cycle pulse on successful completion
//            error        - one-cycle pulse on wait timeout
// Revision : 1.0 - initial release
// ============================================================================
module mem_xfer_ctrl #(
    parameter int TIMEOUT = 15,
    parameter int CNT_W   = 8
) (
    input  logic clock,
    input  logic clear,
    input  logic start_read,
    input  logic start_write,
    input  logic mem_ready,
    output logic MARin,
    output logic MDRin,
    output logic MDR_read,
    output logic mem_read,
    output logic mem_write,
    output logic busy,
    output logic done,
    output logic error
);

    localparam logic [2:0] c_IDLE   = 3'd0;
    localparam logic [2:0] c_MAR_LD = 3'd1;
    localparam logic [2:0] c_MDR_LD = 3'd2;
    localparam logic [2:0] c_RD_REQ = 3'd3;
    localparam logic [2:0] c_WR_REQ = 3'd4;
    localparam logic [2:0] c_DONE   = 3'd5;
    localparam logic [2:0] c_ERR    = 3'd6;

    // Last wait-counter value before a non-ready cycle becomes a timeout.
    localparam logic [CNT_W-1:0] c_CNT_LAST = CNT_W'(TIMEOUT - 1);

    logic [2:0]       r_state;
    logic [2:0]       w_next;
    logic             r_op_write;
    logic [CNT_W-1:0] r_wait_cnt;
    logic             w_in_req;
    logic             w_cnt_last;

    assign w_in_req   = (r_state == c_RD_REQ) || (r_state == c_WR_REQ);
    assign w_cnt_last = (r_wait_cnt == c_CNT_LAST);

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_next = r_state;
        case (r_state)
            c_IDLE: begin
                if (start_read || start_write) begin
                    w_next = c_MAR_LD;
                end
            end
            c_MAR_LD: w_next = r_op_write ? c_MDR_LD : c_RD_REQ;
            c_MDR_LD: w_next = c_WR_REQ;
            c_RD_REQ, c_WR_REQ: begin
                // A ready on the final allowed cycle still counts as success.
                if (mem_ready) begin
                    w_next = c_DONE;
                end else if (w_cnt_last) begin
                    w_next = c_ERR;
                end
            end
            c_DONE:  w_next = c_IDLE;
            c_ERR:   w_next = c_IDLE;
            default: w_next = c_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // State, op flag and wait counter
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (!clear) begin
            r_state    <= c_IDLE;
            r_op_write <= 1'b0;
            r_wait_cnt <= '0;
        end else begin
            r_state <= w_next;

            // Read wins when both starts arrive together.
            if ((r_state == c_IDLE) && (start_read || start_write)) begin
                r_op_write <= !start_read;
            end

            // Counter sits at zero outside request states, so every request
            // state is entered with a fresh count.
            if (!w_in_req) begin
                r_wait_cnt <= '0;
            end else if (!mem_ready && !w_cnt_last) begin
                r_wait_cnt <= r_wait_cnt + CNT_W'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs: Moore decode of state, except MDRin in RD_REQ which follows
    // mem_ready in the same cycle so MDR captures the returning data.
    // ------------------------------------------------------------------
    assign MARin     = (r_state == c_MAR_LD);
    assign MDRin     = (r_state == c_MDR_LD) || ((r_state == c_RD_REQ) && mem_ready);
    assign MDR_read  = (r_state == c_RD_REQ);
    assign mem_read  = (r_state == c_RD_REQ);
    assign mem_write = (r_state == c_WR_REQ);
    assign busy      = (r_state != c_IDLE);
    assign done      = (r_state == c_DONE);
    assign error     = (r_state == c_ERR);

endmodule
`default_nettype wire

// File: tb/tb_mem_xfer_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_xfer_ctrl
// Purpose  : Directed self-checking bench for mem_xfer_ctrl (TIMEOUT = 4).
//            Each scenario applies a per-cycle stimulus table and compares
//            the packed output vector against hand-derived expectations.
//            Stimulus word : {clear, start_read, start_write, mem_ready}
//            Output word   : {MARin, MDRin, MDR_read, mem_read, mem_write,
//                             busy, done, error}
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_xfer_ctrl;

    logic clock;
    logic clear;
    logic start_read;
    logic start_write;
    logic mem_ready;
    logic MARin;
    logic MDRin;
    logic MDR_read;
    logic mem_read;
    logic mem_write;
    logic busy;
    logic done;
    logic error;

    int n_tests;
    int n_fail;

    mem_xfer_ctrl #(
        .TIMEOUT (4),
        .CNT_W   (8)
    ) dut (
        .clock       (clock),
        .clear       (clear),
        .start_read  (start_read),
        .start_write (start_write),
        .mem_ready   (mem_ready),
        .MARin       (MARin),
        .MDRin       (MDRin),
        .MDR_read    (MDR_read),
        .mem_read    (mem_read),
        .mem_write   (mem_write),
        .busy        (busy),
        .done        (done),
        .error       (error)
    );

    always #5 clock = ~clock;

    // Output patterns used in the tables below.
    localparam logic [7:0] c_O_IDLE = 8'b0000_0000;
    localparam logic [7:0] c_O_MAR  = 8'b1000_0100;
    localparam logic [7:0] c_O_MDRW = 8'b0100_0100;  // MDRin, MDR_read=0
    localparam logic [7:0] c_O_RDW  = 8'b0011_0100;  // read request, waiting
    localparam logic [7:0] c_O_RDOK = 8'b0111_0100;  // read request, ready
    localparam logic [7:0] c_O_WR   = 8'b0000_1100;
    localparam logic [7:0] c_O_DONE = 8'b0000_0110;
    localparam logic [7:0] c_O_ERR  = 8'b0000_0101;

    // Stimulus words {clear, start_read, start_write, mem_ready}
    localparam logic [3:0] c_S_NOP   = 4'b1000;
    localparam logic [3:0] c_S_RDY   = 4'b1001;
    localparam logic [3:0] c_S_RD    = 4'b1100;
    localparam logic [3:0] c_S_RD_R  = 4'b1101;
    localparam logic [3:0] c_S_WR    = 4'b1010;
    localparam logic [3:0] c_S_BOTH  = 4'b1110;
    localparam logic [3:0] c_S_CLR   = 4'b0000;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        logic [3:0] stim [3];
        logic [7:0] expv [3];
        logic [7:0] obs;
        stim = '{4'b0101, c_S_CLR, c_S_NOP};
        expv = '{c_O_IDLE, c_O_IDLE, c_O_IDLE};
        for (int k = 0; k < 3; k++) begin
            {clear, start_read, start_write, mem_ready} = stim[k];
            @(negedge clock);
            obs = {MARin, MDRin, MDR_read, mem_read, mem_write, busy, done, error};
            n_tests++;
            if (obs !== expv[k]) begin
                n_fail++;
                $display("FAIL reset c%0d: got %b expected %b", k, obs, expv[k]);
            end
            tick();
        end
    endtask

    task automatic test_read();
        logic [3:0] stim [5];
        logic [7:0] expv [5];
        logic [7:0] obs;
        stim = '{c_S_RD_R, c_S_RDY, c_S_RDY, c_S_RDY, c_S_RDY};
        expv = '{c_O_IDLE, c_O_MAR, c_O_RDOK, c_O_DONE, c_O_IDLE};
        for (int k = 0; k < 5; k++) begin
            {clear, start_read, start_write, mem_ready} = stim[k];
            @(negedge clock);
            obs = {MARin, MDRin, MDR_read, mem_read, mem_write, busy, done, error};
            n_tests++;
            if (obs !== expv[k]) begin
                n_fail++;
                $display("FAIL read c%0d: got %b expected %b", k, obs, expv[k]);
            end
            tick();
        end
    endtask

    task automatic test_write_wait();
        logic [3:0] stim [9];
        logic [7:0] expv [9];
        logic [7:0] obs;
        stim = '{c_S_WR, c_S_NOP, c_S_NOP, c_S_NOP, c_S_NOP, c_S_NOP,
                 c_S_RDY, c_S_NOP, c_S_NOP};
        expv = '{c_O_IDLE, c_O_MAR, c_O_MDRW, c_O_WR, c_O_WR, c_O_WR,
                 c_O_WR, c_O_DONE, c_O_IDLE};
        for (int k = 0; k < 9; k++) begin
            {clear, start_read, start_write, mem_ready} = stim[k];
            @(negedge clock);
            obs = {MARin, MDRin, MDR_read, mem_read, mem_write, busy, done, error};
            n_tests++;
            if (obs !== expv[k]) begin
                n_fail++;
                $display("FAIL write_wait c%0d: got %b expected %b", k, obs, expv[k]);
            end
            tick();
        end
    endtask

    task automatic test_timeout();
        logic [3:0] stim [8];
        logic [7:0] expv [8];
        logic [7:0] obs;
        stim = '{c_S_RD, c_S_NOP, c_S_NOP, c_S_NOP, c_S_NOP, c_S_NOP,
                 c_S_NOP, c_S_NOP};
        expv = '{c_O_IDLE, c_O_MAR, c_O_RDW, c_O_RDW, c_O_RDW, c_O_RDW,
                 c_O_ERR, c_O_IDLE};
        for (int k = 0; k < 8; k++) begin
            {clear, start_read, start_write, mem_ready} = stim[k];
            @(negedge clock);
            obs = {MARin, MDRin, MDR_read, mem_read, mem_write, busy, done, error};
            n_tests++;
            if (obs !== expv[k]) begin
                n_fail++;
                $display("FAIL timeout c%0d: got %b expected %b", k, obs, expv[k]);
            end
            tick();
        end
    endtask

    task automatic test_boundary();
        logic [3:0] stim [8];
        logic [7:0] expv [8];
        logic [7:0] obs;
        stim = '{c_S_RD, c_S_NOP, c_S_NOP, c_S_NOP, c_S_NOP, c_S_RDY,
                 c_S_NOP, c_S_NOP};
        expv = '{c_O_IDLE, c_O_MAR, c_O_RDW, c_O_RDW, c_O_RDW, c_O_RDOK,
                 c_O_DONE, c_O_IDLE};
        for (int k = 0; k < 8; k++) begin
            {clear, start_read, start_write, mem_ready} = stim[k];
            @(negedge clock);
            obs = {MARin, MDRin, MDR_read, mem_read, mem_write, busy, done, error};
            n_tests++;
            if (obs !== expv[k]) begin
                n_fail++;
                $display("FAIL boundary c%0d: got %b expected %b", k, obs, expv[k]);
            end
            tick();
        end
    endtask

    // Both starts together (read wins), a write start during RD_REQ and a
    // read start during DONE must all be ignored beyond the first read.
    task automatic test_back_to_back();
        logic [3:0] stim [7];
        logic [7:0] expv [7];
        logic [7:0] obs;
        stim = '{c_S_BOTH, c_S_NOP, c_S_WR, c_S_RDY, c_S_RD, c_S_NOP, c_S_NOP};
        expv = '{c_O_IDLE, c_O_MAR, c_O_RDW, c_O_RDOK, c_O_DONE, c_O_IDLE,
                 c_O_IDLE};
        for (int k = 0; k < 7; k++) begin
            {clear, start_read, start_write, mem_ready} = stim[k];
            @(negedge clock);
            obs = {MARin, MDRin, MDR_read, mem_read, mem_write, busy, done, error};
            n_tests++;
            if (obs !== expv[k]) begin
                n_fail++;
                $display("FAIL back_to_back c%0d: got %b expected %b", k, obs, expv[k]);
            end
            tick();
        end
    endtask

    // clear pulled low during WR_REQ, then a fresh read afterwards.
    task automatic test_clear_midxfer();
        logic [3:0] stim [10];
        logic [7:0] expv [10];
        logic [7:0] obs;
        stim = '{c_S_WR, c_S_NOP, c_S_NOP, c_S_CLR, c_S_NOP, c_S_RD_R,
                 c_S_RDY, c_S_RDY, c_S_RDY, c_S_NOP};
        expv = '{c_O_IDLE, c_O_MAR, c_O_MDRW, c_O_WR, c_O_IDLE, c_O_IDLE,
                 c_O_MAR, c_O_RDOK, c_O_DONE, c_O_IDLE};
        for (int k = 0; k < 10; k++) begin
            {clear, start_read, start_write, mem_ready} = stim[k];
            @(negedge clock);
            obs = {MARin, MDRin, MDR_read, mem_read, mem_write, busy, done, error};
            n_tests++;
            if (obs !== expv[k]) begin
                n_fail++;
                $display("FAIL clear_midxfer c%0d: got %b expected %b", k, obs, expv[k]);
            end
            tick();
        end
    endtask

    initial begin
        n_tests     = 0;
        n_fail      = 0;
        clock       = 1'b0;
        clear       = 1'b0;
        start_read  = 1'b0;
        start_write = 1'b0;
        mem_ready   = 1'b0;
        tick();

        test_reset();
        test_read();
        test_write_wait();
        test_timeout();
        test_boundary();
        test_back_to_back();
        test_clear_midxfer();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
